seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 39 +++
 rtl/seg_tick_gen.sv | 38 +++
 rtl/seg_scan_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared constants and types for the 4-digit seven-segment scan controller.
//   CODE_W     : width of one display code
//   NDIG       : number of multiplexed digits
//   CODE_BLANK : code the cathode decoder renders as all segments off
//   CODE_DASH  : code the cathode decoder renders as a centre dash
//   scan_state_e : scan FSM encoding (guard gap / anode drive)
// ---------------------------------------------------------------------------
package seg_pkg;

  localparam int CODE_W = 5;
  localparam int NDIG   = 4;

  localparam logic [CODE_W-1:0] CODE_BLANK = 5'd16;
  localparam logic [CODE_W-1:0] CODE_DASH  = 5'd17;

  typedef enum logic {
    S_GUARD = 1'b0,
    S_DRIVE = 1'b1
  } scan_state_e;

  // Codes beyond the last defined glyph are shown as blank rather than
  // passing an undefined value to the cathode decoder.
  function automatic logic [CODE_W-1:0] clamp_code(input logic [CODE_W-1:0] code);
    if (code > CODE_DASH) begin
      clamp_code = CODE_BLANK;
    end else begin
      clamp_code = code;
    end
  endfunction

  // Extract the code of digit idx from a packed four-digit vector.
  function automatic logic [CODE_W-1:0] pick_digit(input logic [NDIG*CODE_W-1:0] vec,
                                                   input logic [1:0]             idx);
    pick_digit = vec[idx*CODE_W +: CODE_W];
  endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// ---------------------------------------------------------------------------
// seg_tick_gen
// Free-running modulo-N counter; o_tick is high for one cycle out of every N,
// on the cycle where the count sits at N-1.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset (count cleared to 0)
//   o_tick : terminal-count pulse
// ---------------------------------------------------------------------------
module seg_tick_gen #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam int              CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);

  // Modulo-N count, restarting from zero after the terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tick = w_last;

endmodule

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed anode scanner for a 4-digit seven-segment display.
// Each digit gets GUARD all-off cycles followed by SCAN_DIV driven cycles.
// Digit codes are double-buffered so that a frame never mixes old and new
// digits, and per-digit blank / blink masks are applied as the digit starts.
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   digits_i     : four 5-bit codes, [4:0]=digit0 (rightmost) .. [19:15]=digit3
//   load_i       : one-cycle strobe capturing digits_i into the pending buffer
//   blank_mask_i : bit i forces digit i blank
//   blink_mask_i : bit i forces digit i blank during the blink-on phase
//   an_o         : active-low anode enables, bit i drives digit i
//   code_o       : code of the driven digit to the cathode decoder
//   frame_done_o : one-cycle pulse on the last drive cycle of digit 3
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int GUARD     = 16,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NDIG*CODE_W-1:0]   digits_i,
  input  logic                     load_i,
  input  logic [NDIG-1:0]          blank_mask_i,
  input  logic [NDIG-1:0]          blink_mask_i,
  output logic [NDIG-1:0]          an_o,
  output logic [CODE_W-1:0]        code_o,
  output logic                     frame_done_o
);

  // One counter serves both phases, so it must hold the larger terminal count.
  localparam int CNT_MAX = (SCAN_DIV > GUARD) ? SCAN_DIV : GUARD;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DRIVE_PRE  = CNT_W'(SCAN_DIV - 2);

  localparam logic [NDIG*CODE_W-1:0] ALL_BLANK = {NDIG{CODE_BLANK}};

  // Scan FSM state
  scan_state_e        r_state;
  logic [1:0]         r_idx;
  logic [CNT_W-1:0]   r_cnt;
  scan_state_e        w_state_nxt;
  logic [1:0]         w_idx_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  // Registered outputs and their next values
  logic [NDIG-1:0]    r_an;
  logic [CODE_W-1:0]  r_code;
  logic               r_frame_done;
  logic [NDIG-1:0]    w_an_nxt;
  logic [CODE_W-1:0]  w_code_nxt;
  logic               w_frame_done_nxt;

  // Digit buffers
  logic [NDIG*CODE_W-1:0] r_pending;
  logic [NDIG*CODE_W-1:0] r_active;
  logic [NDIG*CODE_W-1:0] w_pending_nxt;
  logic [NDIG*CODE_W-1:0] w_active_nxt;

  // Blink phase
  logic               r_blink;
  logic               w_blink_tick;

  // Guard entry / frame boundary qualifiers
  logic               w_entry;
  logic               w_boundary;
  logic [CODE_W-1:0]  w_sel;

  seg_tick_gen #(
    .N (BLINK_DIV)
  ) u_blink_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_tick (w_blink_tick)
  );

  // First cycle of a digit's guard gap; with idx 0 it is the frame boundary.
  assign w_entry    = (r_state == S_GUARD) && (r_cnt == '0);
  assign w_boundary = w_entry && (r_idx == 2'd0);

  // Scan FSM next state, plus next anode pattern and frame pulse so both can
  // be registered in step with the state they describe.
  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_cnt_nxt        = r_cnt + CNT_W'(1);
    w_an_nxt         = 4'b1111;
    w_frame_done_nxt = 1'b0;

    case (r_state)
      S_GUARD: begin
        if (r_cnt == GUARD_LAST) begin
          w_state_nxt = S_DRIVE;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = S_GUARD;
        end
      end
      S_DRIVE: begin
        if (r_cnt == DRIVE_LAST) begin
          w_state_nxt = S_GUARD;
          w_cnt_nxt   = '0;
          if (r_idx == 2'd3) begin
            w_idx_nxt = 2'd0;
          end else begin
            w_idx_nxt = r_idx + 2'd1;
          end
        end else begin
          w_state_nxt = S_DRIVE;
        end
        // The next cycle is the last drive cycle of digit 3.
        if ((r_idx == 2'd3) && (r_cnt == DRIVE_PRE)) begin
          w_frame_done_nxt = 1'b1;
        end else begin
          w_frame_done_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_GUARD;
        w_idx_nxt   = 2'd0;
        w_cnt_nxt   = '0;
      end
    endcase

    if (w_state_nxt == S_DRIVE) begin
      w_an_nxt = ~(4'b0001 << w_idx_nxt);
    end else begin
      w_an_nxt = 4'b1111;
    end
  end

  // Pending follows every load; active swaps only at the frame boundary,
  // taking a same-cycle load directly so it is not a frame late.
  always_comb begin
    w_pending_nxt = r_pending;
    w_active_nxt  = r_active;
    if (load_i) begin
      w_pending_nxt = digits_i;
    end else begin
      w_pending_nxt = r_pending;
    end
    if (w_boundary) begin
      w_active_nxt = w_pending_nxt;
    end else begin
      w_active_nxt = r_active;
    end
  end

  // Digit code, resolved once at guard entry and then held for the digit.
  always_comb begin
    w_sel      = pick_digit(w_active_nxt, r_idx);
    w_code_nxt = r_code;
    if (!w_entry) begin
      w_code_nxt = r_code;
    end else if (blank_mask_i[r_idx] || (blink_mask_i[r_idx] && r_blink)) begin
      w_code_nxt = CODE_BLANK;
    end else begin
      w_code_nxt = clamp_code(w_sel);
    end
  end

  // Scan FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_GUARD;
      r_idx   <= 2'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Pending and active digit buffers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= ALL_BLANK;
      r_active  <= ALL_BLANK;
    end else begin
      r_pending <= w_pending_nxt;
      r_active  <= w_active_nxt;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an         <= 4'b1111;
      r_code       <= CODE_BLANK;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= w_an_nxt;
      r_code       <= w_code_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  // Free-running blink phase, independent of the scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink <= 1'b0;
    end else if (w_blink_tick) begin
      r_blink <= ~r_blink;
    end else begin
      r_blink <= r_blink;
    end
  end

  assign an_o         = r_an;
  assign code_o       = r_code;
  assign frame_done_o = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Directed bench for seg_scan_ctrl with SCAN_DIV=4, GUARD=1, BLINK_DIV=64.
// Timeline: cycle 0 is the first cycle after reset release. Each digit spans
// 5 cycles (1 guard + 4 drive), a frame 20 cycles. A digit's code is sampled
// in its guard cycle and appears on code_o from the next cycle, so code_o in
// cycle c (c>=1) belongs to digit ((c-1)%20)/5.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic [19:0] digits_i;
  logic        load_i;
  logic [3:0]  blank_mask_i;
  logic [3:0]  blink_mask_i;
  logic [3:0]  an_o;
  logic [4:0]  code_o;
  logic        frame_done_o;

  int tests;
  int fails;
  int fd_seen;

  logic [4:0] blink_tab [10];

  seg_scan_ctrl #(
    .SCAN_DIV  (4),
    .GUARD     (1),
    .BLINK_DIV (64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .digits_i     (digits_i),
    .load_i       (load_i),
    .blank_mask_i (blank_mask_i),
    .blink_mask_i (blink_mask_i),
    .an_o         (an_o),
    .code_o       (code_o),
    .frame_done_o (frame_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int c, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, c, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_an(input int pos);
    if ((pos % 5) == 0) return 4'b1111;
    return ~(4'b0001 << (pos / 5));
  endfunction

  // Advance through cycles from..to, checking anodes, frame pulse and code.
  task automatic run_frames(input int from, input int to,
                            input logic [4:0] d0, input logic [4:0] d1,
                            input logic [4:0] d2, input logic [4:0] d3);
    logic [4:0] d [4];
    int pos;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int c = from; c <= to; c++) begin
      step();
      pos = c % 20;
      chk("an_o", c, {4'b0000, an_o}, {4'b0000, exp_an(pos)});
      chk("frame_done_o", c, {7'b0, frame_done_o}, {7'b0, (pos == 19)});
      chk("code_o", c, {3'b000, code_o}, {3'b000, d[((c - 1) % 20) / 5]});
      if (frame_done_o) fd_seen++;
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    fd_seen = 0;
    blink_tab = '{5'd9, 5'd9, 5'd9, 5'd16, 5'd16, 5'd16, 5'd9, 5'd9, 5'd9, 5'd16};

    rst_n = 1'b0;
    digits_i = 20'd0;
    load_i = 1'b0;
    blank_mask_i = 4'b0000;
    blink_mask_i = 4'b0000;

    // Held in reset
    step(); step(); step();
    chk("rst_an", -1, {4'b0000, an_o}, 8'h0F);
    chk("rst_code", -1, {3'b000, code_o}, 8'd16);
    chk("rst_fd", -1, {7'b0, frame_done_o}, 8'd0);

    // Release together with a load of 3,2,1,0 on the first (boundary) cycle
    digits_i = {5'd3, 5'd2, 5'd1, 5'd0};
    load_i = 1'b1;
    rst_n = 1'b1;
    chk("c0_an", 0, {4'b0000, an_o}, 8'h0F);
    chk("c0_code", 0, {3'b000, code_o}, 8'd16);
    run_frames(1, 1, 5'd0, 5'd1, 5'd2, 5'd3);
    load_i = 1'b0;
    run_frames(2, 40, 5'd0, 5'd1, 5'd2, 5'd3);
    chk("frame_pulses", 40, 8'(fd_seen), 8'd2);

    // Two loads during idx=1 drive: last wins, applied from next frame
    run_frames(41, 47, 5'd0, 5'd1, 5'd2, 5'd3);
    digits_i = {5'd15, 5'd14, 5'd13, 5'd12};
    load_i = 1'b1;
    run_frames(48, 48, 5'd0, 5'd1, 5'd2, 5'd3);
    digits_i = {5'd7, 5'd6, 5'd5, 5'd4};
    run_frames(49, 49, 5'd0, 5'd1, 5'd2, 5'd3);
    load_i = 1'b0;
    run_frames(50, 60, 5'd0, 5'd1, 5'd2, 5'd3);
    run_frames(61, 80, 5'd4, 5'd5, 5'd6, 5'd7);

    // Load on the boundary cycle (cycle 80): shown in this frame; 31 -> 16
    digits_i = {5'd31, 5'd9, 5'd17, 5'd10};
    load_i = 1'b1;
    run_frames(81, 81, 5'd10, 5'd17, 5'd9, 5'd16);
    load_i = 1'b0;
    run_frames(82, 100, 5'd10, 5'd17, 5'd9, 5'd16);

    // Blank all digits, then clear the mask
    blank_mask_i = 4'b1111;
    run_frames(101, 120, 5'd16, 5'd16, 5'd16, 5'd16);
    blank_mask_i = 4'b0000;
    run_frames(121, 140, 5'd10, 5'd17, 5'd9, 5'd16);

    // Blink digit 2; phase is (sample_cycle/64)&1 with samples at 20f+10
    blink_mask_i = 4'b0100;
    for (int f = 0; f < 10; f++) begin
      run_frames(141 + 20 * f, 160 + 20 * f, 5'd10, 5'd17, blink_tab[f], 5'd16);
    end
    blink_mask_i = 4'b0000;

    // Asynchronous reset while driving digit 2 (cycle 352)
    run_frames(341, 352, 5'd10, 5'd17, 5'd9, 5'd16);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_an", 352, {4'b0000, an_o}, 8'h0F);
    chk("async_rst_code", 352, {3'b000, code_o}, 8'd16);
    chk("async_rst_fd", 352, {7'b0, frame_done_o}, 8'd0);
    digits_i = {5'd1, 5'd1, 5'd1, 5'd1};
    load_i = 1'b1;
    step();
    chk("rst_hold_an", 353, {4'b0000, an_o}, 8'h0F);
    chk("rst_hold_code", 353, {3'b000, code_o}, 8'd16);
    load_i = 1'b0;
    blink_mask_i = 4'b0001;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Restart: buffers were cleared to blank, blink phase restarts at 0
    chk("restart_an", 0, {4'b0000, an_o}, 8'h0F);
    chk("restart_code", 0, {3'b000, code_o}, 8'd16);
    run_frames(1, 20, 5'd16, 5'd16, 5'd16, 5'd16);
    digits_i = {5'd4, 5'd3, 5'd2, 5'd1};
    load_i = 1'b1;
    run_frames(21, 21, 5'd1, 5'd2, 5'd3, 5'd4);
    load_i = 1'b0;
    run_frames(22, 80, 5'd1, 5'd2, 5'd3, 5'd4);
    run_frames(81, 100, 5'd16, 5'd2, 5'd3, 5'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
